// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a byte FIFO.
// It shares the CPU data bus with the RAM and has the same one-cycle registered read latency.
module mmio_uart_tx #(
    parameter int         DEPTH     = 8,
    parameter int         CLK_DIV   = 4,
    parameter logic [9:0] ADDR_TX   = 10'h001,
    parameter logic [9:0] ADDR_STAT = 10'h002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  mem_addr,
    input  logic [15:0] wr_data,
    input  logic        mem_wr,
    output logic [15:0] rd_data,
    output logic        io_hit,
    output logic        tx
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg;
    logic [7:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_cnt_reg;
    logic [DIV_W-1:0]  div_reg;

    logic fifo_full;
    logic fifo_empty;
    logic busy;
    logic div_done;
    logic tx_wr;
    logic stat_wr;
    logic pop;
    logic push;
    logic unused_hi;

    assign fifo_full  = (count_reg == CNT_FULL);
    assign fifo_empty = (count_reg == '0);
    assign busy       = (state_reg != IDLE);
    assign div_done   = (div_reg == '0);
    assign tx_wr      = mem_wr && (mem_addr == ADDR_TX);
    assign stat_wr    = mem_wr && (mem_addr == ADDR_STAT);
    assign unused_hi  = ^wr_data[15:8];

    // The head leaves the FIFO only when a new frame begins, so a full FIFO
    // can still accept a byte on the same edge the transmitter takes one.
    assign pop  = !fifo_empty && ((state_reg == IDLE) || ((state_reg == STOP) && div_done));
    assign push = tx_wr && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wr_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            div_reg      <= '0;
            tx           <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            if (tx_wr && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (stat_wr && wr_data[2]) begin
                overflow_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr_reg];
                        state_reg <= START;
                        tx        <= 1'b0;
                        div_reg   <= DIV_LOAD;
                    end
                end
                START: begin
                    if (div_done) begin
                        state_reg   <= DATA;
                        tx          <= shift_reg[0];
                        bit_cnt_reg <= '0;
                        div_reg     <= DIV_LOAD;
                    end else begin
                        div_reg <= div_reg - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (div_done) begin
                        div_reg <= DIV_LOAD;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx        <= 1'b1;
                        end else begin
                            // bit 0 is already on the line; shift the next one into view
                            tx          <= shift_reg[1];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        div_reg <= div_reg - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (div_done) begin
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr_reg];
                            state_reg <= START;
                            tx        <= 1'b0;
                            div_reg   <= DIV_LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        div_reg <= div_reg - DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx        <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
            io_hit  <= 1'b0;
        end else if (mem_wr) begin
            io_hit <= 1'b0;
        end else if (mem_addr == ADDR_TX) begin
            rd_data <= 16'(count_reg);
            io_hit  <= 1'b1;
        end else if (mem_addr == ADDR_STAT) begin
            rd_data <= {13'b0, overflow_reg, busy, fifo_full};
            io_hit  <= 1'b1;
        end else begin
            rd_data <= '0;
            io_hit  <= 1'b0;
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped serial output peripheral. It is a bus responder on the CPU data-memory bus (10-bit word address, 16-bit data, single write strobe).
- It sits in parallel with the data RAM. Bytes written to the TX data address are queued in a FIFO and shifted out on a single 8N1 serial line.
- Status is readable with the same 1-cycle registered read latency as the RAM. The top level uses io_hit to mux rd_data between the RAM and this block.

Parameters:
- DEPTH, 8, FIFO depth in bytes; must be a power of two and at least 2.
- CLK_DIV, 4, clock cycles per serial bit; must be at least 1.
- ADDR_TX, 10'h001, word address of the TX data / FIFO level register.
- ADDR_STAT, 10'h002, word address of the status / control register.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-low reset (0 = reset).
- mem_addr, input, 10, word address from the CPU.
- wr_data, input, 16, write data from the CPU.
- mem_wr, input, 1, write strobe; when 0, the cycle is a read of mem_addr.
- rd_data, output, 16, registered read data; valid the cycle after the address.
- io_hit, output, 1, registered; 1 when rd_data comes from this block (the previous cycle was a read of ADDR_TX or ADDR_STAT).
- tx, output, 1, serial line; idles high.

Behaviour:
- Reset (rst=0 at an edge): tx=1, rd_data=0, io_hit=0, FIFO count=0, pointers=0, overflow=0, FSM=IDLE, bit counter and divider=0.
- Reset asserted mid-frame aborts the frame: tx=1 after that edge, FIFO flushed.
- Write to ADDR_TX (mem_wr=1):
  - Pushes wr_data[7:0]; wr_data[15:8] is ignored.
  - If the FIFO is full at that edge and no pop occurs at the same edge, the byte is dropped and overflow is set (sticky).
- Write to ADDR_STAT: if wr_data[2]=1, overflow clears; all other bits are ignored.
- Reads (mem_wr=0), captured at the edge with 1-cycle latency:
  - ADDR_TX returns {zero-extended FIFO count}.
  - ADDR_STAT returns {13'b0, overflow, busy, full}.
  - For any other address, rd_data=0 and io_hit=0.
  - Writes set io_hit=0 and hold rd_data.
- Status definitions: full = (count==DEPTH); busy = (FSM != IDLE).
- Simultaneous push and pop at the same edge: both take effect, count is unchanged, and the push is accepted even when full.
- Simultaneous write to ADDR_STAT clearing overflow and an overflowing push cannot occur (different addresses).
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if count>0, pop the head byte into the shift register, go to START, tx=0.
  - START: hold CLK_DIV cycles, then DATA with tx=bit0.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles, then STOP with tx=1.
  - STOP: hold CLK_DIV cycles. Then, if count>0, pop and enter START directly with no idle cycle; else go to IDLE.
- Latency: a byte written into an empty FIFO with FSM idle at edge E0 drives tx=0 from edge E1.
- Frame length is 10*CLK_DIV cycles; back-to-back frames are contiguous.
- The divider is a down counter reloaded to CLK_DIV-1 on each bit entry.
- The FIFO head is popped only from IDLE or the last STOP cycle.

Test Plan:
1. Hold rst=0 for 2 cycles, release, read ADDR_STAT -> next cycle rd_data=16'h0000, io_hit=1, tx=1.
2. With CLK_DIV=4, write 16'h1241 to ADDR_TX at E0 -> tx=0 for E1..E4; then bits 1,0,0,0,0,0,1,0 at 4 cycles each; then stop high 4 cycles; busy=0 from E41.
3. Write 10 bytes on consecutive edges E0..E9 -> the first is popped at E1; ADDR_TX reads 8 after E9; status=16'h0007 (overflow, busy, full); the 10th byte never appears on tx; 9 contiguous frames, 360 cycles.
4. Mid-frame reads: ADDR_STAT -> 16'h0002 with io_hit=1; ADDR_TX -> count; address 10'h100 -> io_hit=0, rd_data=0.
5. After overflow, write 16'h0004 to ADDR_STAT -> the next status read has bit2=0, and bits 1:0 are unchanged.
6. Assert rst=0 for one cycle during the DATA phase -> tx=1 the next cycle, count=0, busy=0; a new write then produces a clean frame.
